cir_reg_w_ctrl: RTL and testbench
=================================

// Module: cir_reg_w_ctrl
// PURPOSE
//   Sequencer for the K_H x K_W circular weight register. Accepts K_W weight columns over a
//   valid/ready stream and drives the register's load_en. Then issues shift pulses for a
//   commanded number of convolution windows. Drives clear on command.
//   Sits between the weight-fetch path and one PE's circular weight register.
// PARAMETERS
//   K_H    3   kernel height (bytes per weight column)
//   K_W    3   kernel width (columns per window; shifts per window)
//   WIN_W  8   width of the window-count command
// PORTS
//   clk          in   1        clock
//   rst          in   1        asynchronous reset, active-high
//   load_start   in   1        pulse: begin loading K_W columns
//   w_valid      in   1        weight column valid
//   w_ready      out  1        weight column accepted (high only in LOAD)
//   w_data       in   8xK_H    weight column in
//   reg_in_data  out  8xK_H    to register in_data; combinational pass-through of w_data
//   reg_load_en  out  1        = w_valid & w_ready
//   reg_shift    out  1        circular shift strobe
//   reg_clear    out  1        register clear strobe
//   start        in   1        pulse: run num_windows windows
//   num_windows  in   WIN_W    window count, latched on accepted start
//   clear_req    in   1        pulse: clear register and return to IDLE
//   col_idx      out  $clog2(K_W)  column index of the current shift
//   win_done     out  1        high on the last shift of each window
//   done         out  1        1-cycle pulse after the final shift of a run
//   loaded       out  1        register holds a complete weight set
//   busy         out  1        state is LOAD, RUN or CLR
//   stall        in   1        only with CIR_W_CTRL_STALL_EN
// BEHAVIOUR
//   States: IDLE, LOAD, HOLD, RUN, CLR. Reset -> IDLE.
//     All counters are 0 at reset. All outputs are 0 at reset (reg_in_data follows w_data).
//   IDLE: load_start -> LOAD.
//   HOLD: load_start -> LOAD and loaded<=0 (reload). Otherwise start -> RUN and
//     num_windows is latched. load_start wins over start.
//   LOAD: w_ready=1. Each handshake gives reg_load_en=1 and ld_cnt++.
//     A handshake with ld_cnt==K_W-1 -> HOLD, loaded<=1, ld_cnt<=0. Gaps in w_valid stall only.
//   RUN: reg_shift=1 every cycle. col_idx counts 0..K_W-1 and wraps.
//     win_done=1 when col_idx==K_W-1, and win_cnt++ on that cycle.
//     On win_done with win_cnt==latched-1: next state HOLD, done=1 on the next cycle.
//     The circular register is back at its origin, so loaded stays 1.
//   num_windows==0 on start: no shifts. RUN is not entered. done pulses 1 cycle after start. Stay HOLD.
//   start or load_start outside the states listed above: ignored. No queuing.
//   clear_req in any state: next state CLR, which asserts reg_clear for exactly 1 cycle.
//     Also in CLR: loaded<=0, all counters <=0, then -> IDLE.
//     clear_req beats start and load_start in the same cycle.
//     A clear mid-RUN or mid-LOAD aborts the operation and does not produce done.
//   rst asserted mid-operation: immediate return to reset state. reg_shift, reg_load_en and reg_clear deassert.
//   reg_shift and reg_load_en are never high in the same cycle.
// CONFIGURATION
//   CIR_W_CTRL_STALL_EN defined:
//     stall port exists. In RUN, stall=1 forces reg_shift=0 and freezes col_idx, win_cnt and win_done.
//     In LOAD, stall=1 forces w_ready=0.
//   Undefined: no stall port. Behaviour as if stall=0.
// STRUCTURE
//   Package cir_w_ctrl_pkg holds:
//     - the state enum type cir_w_state_t
//     - localparam helpers for counter widths ($clog2(K_W)).
//   Sub-module cir_w_ctrl_cnt: a parameterised up-counter with clr, inc and terminal-count flag.
//     It is instantiated for ld_cnt, col_idx and win_cnt.
// TESTING
//   - Load (K_W=3): load_start, 3 columns with a 2-cycle w_valid gap.
//     -> 3 reg_load_en pulses, w_ready low after the 3rd, loaded=1, state HOLD.
//   - start, num_windows=4 -> 12 consecutive reg_shift.
//     -> col_idx 0,1,2 repeating; win_done on shifts 3,6,9,12; done 1 cycle after shift 12; loaded stays 1.
//   - start, num_windows=0 -> no reg_shift, done pulses 1 cycle later, state HOLD.
//   - clear_req during shift 5 of a run.
//     -> reg_shift low next cycle, reg_clear 1 cycle, loaded=0, no done, then IDLE.
//     Same-cycle clear_req and start -> clear wins.
//   - rst mid-LOAD after 1 column -> all outputs 0. A new load requires 3 fresh columns.
//   - With CIR_W_CTRL_STALL_EN: stall high 2 cycles mid-window in a num_windows=1 run.
//     -> exactly 3 shifts total, done 2 cycles later than without stall.

Source files
------------

// File: rtl/cir_w_ctrl_pkg.sv
// Shared types and width helpers for the circular weight register sequencer.
package cir_w_ctrl_pkg;

    localparam int unsigned K_H_DEF   = 3;
    localparam int unsigned K_W_DEF   = 3;
    localparam int unsigned WIN_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_CLR  = 3'd4
    } cir_w_state_t;

    // Counter width for a modulo-n index; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned COL_W_DEF = cnt_w(K_W_DEF);

endpackage

// File: rtl/cir_w_ctrl_cnt.sv
// Up-counter with synchronous clear, increment and a programmable terminal value.
// Incrementing at the terminal value wraps to zero.
module cir_w_ctrl_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/cir_reg_w_ctrl.sv
// Sequencer for a K_H x K_W circular weight register: loads columns, shifts windows, clears.
// Optional macro CIR_W_CTRL_STALL_EN adds a stall input that pauses LOAD and RUN.
module cir_reg_w_ctrl
    import cir_w_ctrl_pkg::*;
#(
    parameter int unsigned K_H   = K_H_DEF,
    parameter int unsigned K_W   = K_W_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef CIR_W_CTRL_STALL_EN
    input  logic                    stall,
`endif
    input  logic                    load_start,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [8*K_H-1:0]        w_data,
    output logic [8*K_H-1:0]        reg_in_data,
    output logic                    reg_load_en,
    output logic                    reg_shift,
    output logic                    reg_clear,
    input  logic                    start,
    input  logic [WIN_W-1:0]        num_windows,
    input  logic                    clear_req,
    output logic [cnt_w(K_W)-1:0]   col_idx,
    output logic                    win_done,
    output logic                    done,
    output logic                    loaded,
    output logic                    busy
);

    localparam int unsigned COL_W = cnt_w(K_W);

    cir_w_state_t     state;
    logic [WIN_W-1:0] nwin_lat;
    logic [WIN_W-1:0] win_cnt;
    logic [COL_W-1:0] ld_cnt;
    logic             ld_tc;
    logic             col_tc;
    logic             win_tc;
    logic             stall_int;
    logic             in_clr;

`ifdef CIR_W_CTRL_STALL_EN
    assign stall_int = stall;
`else
    assign stall_int = 1'b0;
`endif

    // Strobes decoded from the registered state; stall gates them in the same cycle.
    assign in_clr      = (state == ST_CLR);
    assign reg_in_data = w_data;
    assign w_ready     = (state == ST_LOAD) && !stall_int;
    assign reg_load_en = w_valid && w_ready;
    assign reg_shift   = (state == ST_RUN) && !stall_int;
    assign reg_clear   = in_clr;
    assign win_done    = reg_shift && col_tc;
    assign busy        = (state == ST_LOAD) || (state == ST_RUN) || in_clr;

    cir_w_ctrl_cnt #(.W(COL_W)) u_ld_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (in_clr),
        .inc  (reg_load_en),
        .last (COL_W'(K_W - 1)),
        .cnt  (ld_cnt),
        .tc   (ld_tc)
    );

    cir_w_ctrl_cnt #(.W(COL_W)) u_col_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (in_clr),
        .inc  (reg_shift),
        .last (COL_W'(K_W - 1)),
        .cnt  (col_idx),
        .tc   (col_tc)
    );

    // Terminal value is the last window of the latched run; wraps to 0 for the next run.
    cir_w_ctrl_cnt #(.W(WIN_W)) u_win_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (in_clr),
        .inc  (win_done),
        .last (nwin_lat - WIN_W'(1)),
        .cnt  (win_cnt),
        .tc   (win_tc)
    );

    // Control FSM; clear_req overrides every other request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            loaded   <= 1'b0;
            done     <= 1'b0;
            nwin_lat <= '0;
        end else begin
            done <= 1'b0;
            if (in_clr) begin
                loaded <= 1'b0;
            end
            if (clear_req) begin
                state <= ST_CLR;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_start) begin
                            state <= ST_LOAD;
                        end
                    end
                    ST_HOLD: begin
                        if (load_start) begin
                            state  <= ST_LOAD;
                            loaded <= 1'b0;
                        end else if (start) begin
                            nwin_lat <= num_windows;
                            if (num_windows == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (reg_load_en && ld_tc) begin
                            state  <= ST_HOLD;
                            loaded <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (win_done && win_tc) begin
                            state <= ST_HOLD;
                            done  <= 1'b1;
                        end
                    end
                    ST_CLR: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cir_reg_w_ctrl.sv
// Randomised self-checking bench for cir_reg_w_ctrl; expectations follow the load/run/clear rules.
module tb_cir_reg_w_ctrl;

    localparam int unsigned K_H   = 3;
    localparam int unsigned K_W   = 3;
    localparam int unsigned WIN_W = 8;
    localparam int unsigned CW    = $clog2(K_W);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_start = 1'b0;
    logic               w_valid = 1'b0;
    logic               start = 1'b0;
    logic               clear_req = 1'b0;
    logic [8*K_H-1:0]   w_data = '0;
    logic [WIN_W-1:0]   num_windows = '0;
    logic [8*K_H-1:0]   reg_in_data;
    logic               w_ready, reg_load_en, reg_shift, reg_clear;
    logic               win_done, done, loaded, busy;
    logic [CW-1:0]      col_idx;
`ifdef CIR_W_CTRL_STALL_EN
    logic               stall = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit m_loaded = 1'b0;

    always #5 clk = ~clk;

    cir_reg_w_ctrl #(.K_H(K_H), .K_W(K_W), .WIN_W(WIN_W)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CIR_W_CTRL_STALL_EN
        .stall       (stall),
`endif
        .load_start  (load_start),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .reg_in_data (reg_in_data),
        .reg_load_en (reg_load_en),
        .reg_shift   (reg_shift),
        .reg_clear   (reg_clear),
        .start       (start),
        .num_windows (num_windows),
        .clear_req   (clear_req),
        .col_idx     (col_idx),
        .win_done    (win_done),
        .done        (done),
        .loaded      (loaded),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare the strobe outputs of the current cycle; e_col < 0 skips col_idx.
    task automatic obs(input string tag, input bit e_rdy, input bit e_ld, input bit e_sh,
                       input bit e_clr, input bit e_wd, input bit e_dn, input bit e_bsy,
                       input int e_col);
        @(negedge clk);
        check({tag, ".w_ready"},     64'(w_ready),     64'(e_rdy));
        check({tag, ".reg_load_en"}, 64'(reg_load_en), 64'(e_ld));
        check({tag, ".reg_shift"},   64'(reg_shift),   64'(e_sh));
        check({tag, ".reg_clear"},   64'(reg_clear),   64'(e_clr));
        check({tag, ".win_done"},    64'(win_done),    64'(e_wd));
        check({tag, ".done"},        64'(done),        64'(e_dn));
        check({tag, ".busy"},        64'(busy),        64'(e_bsy));
        check({tag, ".reg_in_data"}, 64'(reg_in_data), 64'(w_data));
        if (e_col >= 0) check({tag, ".col_idx"}, 64'(col_idx), 64'(e_col));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Abort sequence: one CLR cycle then IDLE with an empty register.
    task automatic clear_tail();
        obs("clr", 0, 0, 0, 1, 0, 0, 1, -1);
        adv();
        obs("clr_idle", 0, 0, 0, 0, 0, 0, 0, -1);
        check("clr_idle.loaded", 64'(loaded), 64'(0));
        adv();
        m_loaded = 1'b0;
    endtask

    // Load K_W columns; fixed_gap >= 0 puts that many idle cycles before column 1.
    task automatic do_load(input int fixed_gap);
        int gap;
        load_start = 1'b1;
        w_valid = 1'($urandom_range(0, 1));
        w_data = (8*K_H)'($urandom);
        obs("ld_req", 0, 0, 0, 0, 0, 0, 0, -1);
        check("ld_req.loaded", 64'(loaded), 64'(m_loaded));
        adv();
        load_start = 1'b0;
        for (int c = 0; c < int'(K_W); c++) begin
            gap = (fixed_gap >= 0) ? ((c == 1) ? fixed_gap : 0) : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                w_valid = 1'b0;
                w_data = (8*K_H)'($urandom);
                start = 1'($urandom_range(0, 1));
                obs("ld_gap", 1, 0, 0, 0, 0, 0, 1, -1);
                check("ld_gap.loaded", 64'(loaded), 64'(0));
                adv();
            end
            w_valid = 1'b1;
            w_data = (8*K_H)'($urandom);
            start = 1'($urandom_range(0, 1));
            obs("ld_hs", 1, 1, 0, 0, 0, 0, 1, -1);
            check("ld_hs.loaded", 64'(loaded), 64'(0));
            adv();
        end
        start = 1'b0;
        w_valid = 1'($urandom_range(0, 1));
        obs("ld_end", 0, 0, 0, 0, 0, 0, 0, -1);
        check("ld_end.loaded", 64'(loaded), 64'(1));
        adv();
        w_valid = 1'b0;
        m_loaded = 1'b1;
    endtask

    // Load aborted by clear_req after h completed columns.
    task automatic do_load_abort(input int h);
        bit v;
        load_start = 1'b1;
        obs("lda_req", 0, 0, 0, 0, 0, 0, 0, -1);
        adv();
        load_start = 1'b0;
        for (int c = 0; c < h; c++) begin
            w_valid = 1'b1;
            w_data = (8*K_H)'($urandom);
            obs("lda_hs", 1, 1, 0, 0, 0, 0, 1, -1);
            adv();
        end
        v = 1'($urandom_range(0, 1));
        w_valid = v;
        clear_req = 1'b1;
        obs("lda_clr", 1, v, 0, 0, 0, 0, 1, -1);
        adv();
        clear_req = 1'b0;
        w_valid = 1'b0;
        clear_tail();
    endtask

    // Run n windows from HOLD; abort_at >= 0 raises clear_req during that shift index.
    task automatic do_run(input int n, input int abort_at);
        start = 1'b1;
        num_windows = WIN_W'(n);
        obs("run_req", 0, 0, 0, 0, 0, 0, 0, -1);
        adv();
        start = 1'b0;
        num_windows = WIN_W'($urandom);
        if (n == 0) begin
            obs("run0_done", 0, 0, 0, 0, 0, 1, 0, -1);
            check("run0_done.loaded", 64'(loaded), 64'(1));
            adv();
            obs("run0_after", 0, 0, 0, 0, 0, 0, 0, -1);
            adv();
            return;
        end
        for (int i = 0; i < n * int'(K_W); i++) begin
            load_start = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            w_valid = 1'($urandom_range(0, 1));
            clear_req = (i == abort_at);
            obs("run_sh", 0, 0, 1, 0, (i % int'(K_W)) == int'(K_W) - 1, 0, 1, i % int'(K_W));
            check("run_sh.loaded", 64'(loaded), 64'(1));
            adv();
            if (i == abort_at) begin
                clear_req = 1'b0;
                load_start = 1'b0;
                start = 1'b0;
                w_valid = 1'b0;
                clear_tail();
                return;
            end
        end
        load_start = 1'b0;
        start = 1'b0;
        w_valid = 1'b0;
        obs("run_done", 0, 0, 0, 0, 0, 1, 0, -1);
        check("run_done.loaded", 64'(loaded), 64'(1));
        adv();
        obs("run_after", 0, 0, 0, 0, 0, 0, 0, -1);
        adv();
    endtask

    // Same-cycle clear_req and start in HOLD: the clear wins.
    task automatic clear_with_start();
        start = 1'b1;
        num_windows = WIN_W'($urandom_range(1, 5));
        clear_req = 1'b1;
        obs("cws_req", 0, 0, 0, 0, 0, 0, 0, -1);
        adv();
        start = 1'b0;
        clear_req = 1'b0;
        clear_tail();
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        obs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset.loaded", 64'(loaded), 64'(0));
        adv();
        rst = 1'b0;

        // start in IDLE is dropped
        start = 1'b1;
        num_windows = WIN_W'(5);
        obs("idle_start", 0, 0, 0, 0, 0, 0, 0, -1);
        adv();
        start = 1'b0;
        obs("idle_after", 0, 0, 0, 0, 0, 0, 0, -1);
        adv();

        do_load(2);
        do_run(4, -1);
        do_run(0, -1);
        do_run(4, 4);
        do_load(0);
        clear_with_start();

        // Reset in the middle of a load discards the partial column count
        do_load_abort(0);
        load_start = 1'b1;
        adv();
        load_start = 1'b0;
        w_valid = 1'b1;
        w_data = (8*K_H)'($urandom);
        adv();
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid.w_ready", 64'(w_ready), 64'(0));
        check("rst_mid.reg_load_en", 64'(reg_load_en), 64'(0));
        check("rst_mid.busy", 64'(busy), 64'(0));
        obs("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_hold.loaded", 64'(loaded), 64'(0));
        adv();
        rst = 1'b0;
        w_valid = 1'b0;
        m_loaded = 1'b0;
        do_load(-1);

`ifdef CIR_W_CTRL_STALL_EN
        // Two stalled cycles inside a one-window run delay done by two cycles
        start = 1'b1;
        num_windows = WIN_W'(1);
        obs("st_req", 0, 0, 0, 0, 0, 0, 0, -1);
        adv();
        start = 1'b0;
        obs("st_sh0", 0, 0, 1, 0, 0, 0, 1, 0);
        adv();
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            obs("st_hold", 0, 0, 0, 0, 0, 0, 1, 1);
            adv();
        end
        stall = 1'b0;
        obs("st_sh1", 0, 0, 1, 0, 0, 0, 1, 1);
        adv();
        obs("st_sh2", 0, 0, 1, 0, 1, 0, 1, 2);
        adv();
        obs("st_done", 0, 0, 0, 0, 0, 1, 0, -1);
        adv();
`endif

        for (int it = 0; it < 30; it++) begin
            if (!m_loaded) begin
                if ($urandom_range(0, 3) == 0) do_load_abort(int'($urandom_range(0, K_W - 1)));
                else do_load(-1);
            end else begin
                case ($urandom_range(0, 4))
                    0, 1: do_run(int'($urandom_range(0, 5)), -1);
                    2: begin
                        n = int'($urandom_range(1, 4));
                        do_run(n, int'($urandom_range(0, n * K_W - 1)));
                    end
                    3: do_load(-1);
                    default: clear_with_start();
                endcase
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
